// File: rtl/cpu_pkg.sv
// Purpose: constants shared by the multi-cycle CPU datapath (word size, reset vectors).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cpu_pkg;

    // Native datapath word size.
    localparam int XLEN = 32;

    // All-zero datapath word.
    localparam logic [XLEN-1:0] ZERO_WORD = '0;

    // Value the program counter takes on reset.
    localparam logic [XLEN-1:0] PC_RESET_VEC = 32'h0000_0000;

    // Reset value for the general state registers (IR, MDR, A, B, ALUOut).
    localparam logic [XLEN-1:0] REG_RESET_VAL = ZERO_WORD;

endpackage : cpu_pkg

// File: rtl/dff_en_ar.sv
// Purpose: 1-bit D flip-flop with load enable and asynchronous active-high reset.
// Latency: 1 rising clk edge from d_i/en_i to q_o; reset acts immediately.
// Backpressure: none; en_i=0 holds the stored bit.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset, loads RST_BIT
//   en_i  load enable, sampled at the rising edge
//   d_i   data bit to load
//   q_o   stored bit, driven straight from the flop
module dff_en_ar #(
    parameter logic RST_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic d_i,
    output logic q_o
);

    logic q_q;

    // Priority: reset, then load, then hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= RST_BIT;
        end else if (en_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule : dff_en_ar

// File: rtl/reg_32.sv
// Purpose: WIDTH-bit load-enable register (PC, IR, MDR, A/B, ALUOut state element).
// Latency: 1 rising clk edge from D/en to out; rst forces RST_VAL asynchronously.
// Backpressure: none; en=0 holds the stored value.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset; out = RST_VAL while asserted
//   en   load enable, sampled at the rising edge
//   D    WIDTH-bit data to load
//   out  WIDTH-bit stored value, driven directly by flops
module reg_32
    import cpu_pkg::*;
#(
    parameter int               WIDTH   = XLEN,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] out_q;

    // One flop per bit; each bit picks its own reset level from RST_VAL.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        dff_en_ar #(
            .RST_BIT (RST_VAL[i])
        ) u_dff (
            .clk  (clk),
            .rst  (rst),
            .en_i (en),
            .d_i  (D[i]),
            .q_o  (out_q[i])
        );
    end

    assign out = out_q;

`ifndef SYNTHESIS
    // Enable must be a clean 0/1 whenever the register is out of reset.
    a_en_known: assert property (@(posedge clk) !rst |-> !$isunknown(en));

    // Loading an unknown value is almost always an upstream bug.
    a_d_known: assert property (@(posedge clk) (!rst && en) |-> !$isunknown(D));

    // Every load edge must leave exactly the sampled data on the output.
    a_load: assert property (@(posedge clk) disable iff (rst)
                             en |=> (out == $past(D)));
`endif

endmodule : reg_32

// File: tb/tb_reg_32.sv
module tb_reg_32;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] D;
    logic [31:0] out;

    logic        rst8;
    logic        en8;
    logic [7:0]  d8;
    logic [7:0]  out8;

    int n_vec;
    int n_err;

    reg_32 u_dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .D   (D),
        .out (out)
    );

    reg_32 #(
        .WIDTH   (8),
        .RST_VAL (8'hFF)
    ) u_dut8 (
        .clk (clk),
        .rst (rst8),
        .en  (en8),
        .D   (d8),
        .out (out8)
    );

    initial clk = 1'b0;
    always #25 clk = ~clk;

    typedef struct {
        logic        en;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        logic [31:0] prev;

        n_vec = 0;
        n_err = 0;
        rst   = 1'b0;
        en    = 1'b0;
        D     = 32'h0;
        rst8  = 1'b0;
        en8   = 1'b0;
        d8    = 8'h00;

        // Hold with stale data, then walking-value loads.
        vecs[0] = '{en: 1'b0, d: 32'hFFFF_FFFF, exp: 32'h1234_5678};
        vecs[1] = '{en: 1'b0, d: 32'hFFFF_FFFF, exp: 32'h1234_5678};
        vecs[2] = '{en: 1'b0, d: 32'hFFFF_FFFF, exp: 32'h1234_5678};
        vecs[3] = '{en: 1'b0, d: 32'hFFFF_FFFF, exp: 32'h1234_5678};
        vecs[4] = '{en: 1'b1, d: 32'h0000_0001, exp: 32'h0000_0001};
        vecs[5] = '{en: 1'b1, d: 32'h8000_0000, exp: 32'h8000_0000};
        vecs[6] = '{en: 1'b1, d: 32'hA5A5_A5A5, exp: 32'hA5A5_A5A5};

        // 1. Async reset at t=100 with a pending load: immediate zero, held over 3 edges.
        #100;
        rst = 1'b1;
        D   = 32'hDEAD_BEEF;
        en  = 1'b1;
        #1;
        check("rst_immediate", out, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("rst_hold", out, 32'h0);
        end

        // 2. Release and load: value appears only after the edge.
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;
        D   = 32'h1234_5678;
        #1;
        check("load_not_before_edge", out, 32'h0);
        @(posedge clk);
        #1;
        check("load_after_edge", out, 32'h1234_5678);

        // 3/4. Table: hold for 4 edges, then follow D one edge later.
        prev = 32'h1234_5678;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            en = vecs[i].en;
            D  = vecs[i].d;
            #1;
            check("pre_edge_stable", out, prev);
            @(posedge clk);
            #1;
            check("vec", out, vecs[i].exp);
            prev = vecs[i].exp;
        end

        // 5. Reset 12 ns after an edge while holding A5A5A5A5.
        @(negedge clk);
        en = 1'b0;
        @(posedge clk);
        #12;
        check("pre_midreset", out, 32'hA5A5_A5A5);
        rst = 1'b1;
        en  = 1'b1;
        D   = 32'h0000_0055;
        #1;
        check("midreset_immediate", out, 32'h0);
        @(posedge clk);
        #1;
        check("rst_beats_load", out, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("release_no_edge", out, 32'h0);
        @(posedge clk);
        #1;
        check("load_after_release", out, 32'h0000_0055);

        // 6. 8-bit instance with a non-zero reset value.
        @(negedge clk);
        en   = 1'b0;
        rst8 = 1'b1;
        #1;
        check("w8_rst_immediate", {24'h0, out8}, 32'h0000_00FF);
        @(posedge clk);
        #1;
        check("w8_rst_hold", {24'h0, out8}, 32'h0000_00FF);
        @(negedge clk);
        rst8 = 1'b0;
        en8  = 1'b1;
        d8   = 8'h3C;
        #1;
        check("w8_not_before_edge", {24'h0, out8}, 32'h0000_00FF);
        @(posedge clk);
        #1;
        check("w8_load", {24'h0, out8}, 32'h0000_003C);
        @(negedge clk);
        en8 = 1'b0;
        d8  = 8'hC3;
        @(posedge clk);
        #1;
        check("w8_hold", {24'h0, out8}, 32'h0000_003C);
        check("w32_untouched", out, 32'h0000_0055);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_reg_32
